// File: rtl/uart_tx_if.sv
// Byte handshake between a producing datapath and uart_tx.
// The producer holds d_in/d_in_valid until it sees d_in_ready at a rising edge.
interface uart_tx_if;
  logic [7:0] d_in;
  logic       d_in_valid;
  logic       d_in_ready;

  modport master (output d_in, output d_in_valid, input d_in_ready);
  modport slave  (input d_in, input d_in_valid, output d_in_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB-first, even parity, stop. Byte buffer is a
// single holding register by default, or a FIFO_DEPTH circular FIFO when TX_FIFO_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  uart_tx_if.slave in_if,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx: CLKS_PER_BIT must be >= 2, FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             parity_q;
  logic             tx_q;
  logic             busy_q;
  logic             tx_done_q;

  logic             buf_empty;
  logic             buf_full;
  logic [7:0]       head;
  logic             push;
  logic             pop;
  logic             bit_end;

  assign in_if.d_in_ready = !buf_full;
  assign push             = in_if.d_in_valid && !buf_full;
  assign bit_end          = enable && (cnt_q == CNT_LAST);

  // A byte leaves the buffer either from IDLE or on the final stop edge for back-to-back frames.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pop = 1'b0;
    if (!buf_empty && enable) begin
      if (state_q == IDLE) begin
        pop = 1'b1;
      end else if (state_q == STOP && cnt_q == CNT_LAST) begin
        pop = 1'b1;
      end
    end
  end

`ifdef TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit: equal means empty, only the wrap bit differing means full.
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= in_if.d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;

  assign buf_empty = !hold_vld_q;
  assign buf_full  = hold_vld_q;
  assign head      = hold_q;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop) begin
      hold_vld_d = 1'b0;
    end
    if (push) begin
      hold_d     = in_if.d_in;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  // Frame FSM. enable=0 freezes the bit-period counter and every registered output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (enable && state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_ONE;
      end

      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= START;
            shreg_q  <= head;
            parity_q <= ^head;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shreg_q[7];
            bit_idx_q <= 3'd7;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd0) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              bit_idx_q <= bit_idx_q - 3'd1;
              shreg_q   <= {shreg_q[6:0], 1'b0};
              tx_q      <= shreg_q[6];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          // Registered pulse lands on the last stop cycle.
          if (enable && cnt_q == CNT_PRE) begin
            tx_done_q <= 1'b1;
          end
          if (bit_end) begin
            if (pop) begin
              state_q  <= START;
              shreg_q  <= head;
              parity_q <= ^head;
              tx_q     <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line decoder acts as the receiver and compares each
// decoded frame against a scoreboard of bytes accepted at the handshake.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;
`ifdef TX_FIFO_EN
  localparam int DEPTH_EFF = 4;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic tx, busy, tx_done;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .in_if   (bus),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  // Line-decoder state
  bit          mon_on = 1'b0;
  bit          active = 1'b0;
  int          en_cnt, cyc, glitch, busy_low, done_cnt, done_at, stall, mon_b, frame_gap;
  int          gap = 1000;
  int          frames_seen = 0;
  int          total_done = 0;
  int          idle_err = 0;
  logic        bits [11];
  int          bit_len [11];
  int          last_len [11];
  logic [10:0] last_frame;
  logic        last_par;
  int          last_gap, last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_frame();
    logic [7:0] got;
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) got[7-k] = bits[1+k];
    for (int k = 0; k < 11; k++) begin
      last_frame[10-k] = bits[k];
      last_len[k]      = bit_len[k];
    end
    last_par   = bits[9];
    last_gap   = frame_gap;
    last_stall = stall;
    if (sb.size() == 0) begin
      check("sb_underflow", sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      check("data", got, exp);
      check("parity", bits[9], ^exp);
    end
    check("start_bit", bits[0], 1'b0);
    check("stop_bit", bits[10], 1'b1);
    check("bit_glitch", glitch, 0);
    check("busy_in_frame", busy_low, 0);
    check("done_count", done_cnt, 1);
    check("done_pos", done_at, FRAME - 1);
    if (stall == 0) check("frame_len", cyc, FRAME);
    frames_seen++;
  endtask

  // Receiver: counts enabled cycles to locate bit boundaries, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst) begin
        active = 1'b0;
      end else begin
        if (tx_done === 1'b1) total_done++;
        if (!active && tx === 1'b0) begin
          active    = 1'b1;
          en_cnt    = 0;
          cyc       = 0;
          glitch    = 0;
          busy_low  = 0;
          done_cnt  = 0;
          done_at   = -1;
          stall     = 0;
          frame_gap = gap;
          for (int k = 0; k < 11; k++) bit_len[k] = 0;
        end
        if (active) begin
          mon_b = en_cnt / CPB;
          if (bit_len[mon_b] == 0) bits[mon_b] = tx;
          else if (tx !== bits[mon_b]) glitch++;
          bit_len[mon_b]++;
          cyc++;
          if (busy !== 1'b1) busy_low++;
          if (tx_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = en_cnt;
          end
          if (enable === 1'b1) en_cnt++;
          else stall++;
          if (en_cnt == FRAME) begin
            finish_frame();
            active = 1'b0;
            gap    = 0;
          end
        end else begin
          gap++;
          if (busy !== 1'b0 || tx_done !== 1'b0) idle_err++;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    bus.d_in       = b;
    bus.d_in_valid = 1'b1;
    while (!ok && k < budget) begin
      @(negedge clk);
      if (bus.d_in_ready === 1'b1) begin
        @(posedge clk);
        sb.push_back(b);
        ok = 1'b1;
      end
      k++;
    end
    if (!ok) @(posedge clk);
    #1;
    bus.d_in_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [7:0] b);
    bit ok;
    push_byte(b, 4 * FRAME, ok);
    check("push_accept", ok, 1'b1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frames_done", frames_seen, n);
  endtask

  task automatic wait_bit(input int b, input int budget);
    int k = 0;
    while (!(active && en_cnt >= b * CPB + 4) && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("reach_bit", (active && en_cnt >= b * CPB + 4), 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  accepted;
    int  done0;
    bit  ok;
    bus.d_in       = '0;
    bus.d_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ready", bus.d_in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single frame 0xA5
    enable = 1'b1;
    push_ok(8'hA5);
    wait_frames(1, 3 * FRAME);
    check("t1_bits", last_frame, 11'b01010010101);

    // Back-to-back frames, parity 1 then 0, no idle gap
    base = frames_seen;
    push_ok(8'h01);
    push_ok(8'hFF);
    wait_frames(base + 1, 3 * FRAME);
    check("t2_par1", last_par, ^8'h01);
    wait_frames(base + 2, 3 * FRAME);
    check("t2_par2", last_par, ^8'hFF);
    check("t2_gap", last_gap, 0);

    // Fill buffer with enable low; drain in push order
    base = frames_seen;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h10 + 8'(i), 4, ok);
      if (ok) accepted++;
    end
    check("t3_accepted", accepted, DEPTH_EFF);
    @(negedge clk);
    check("t3_ready_full", bus.d_in_ready, 1'b0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_ready_pop", bus.d_in_ready, 1'b1);
    wait_frames(base + DEPTH_EFF, (DEPTH_EFF + 2) * FRAME);

    // Stall 10 cycles inside d[3]
    base = frames_seen;
    push_ok(8'hC3);
    wait_bit(5, 3 * FRAME);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(base + 1, 3 * FRAME);
    check("t4_stall", last_stall, 10);
    for (int k = 0; k < 11; k++) check("t4_bit_len", last_len[k], (k == 5) ? CPB + 10 : CPB);

    // Reset during d[5] with a second byte buffered
    base = frames_seen;
    push_ok(8'h96);
    push_ok(8'h69);
    wait_bit(3, 3 * FRAME);
    done0 = total_done;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_tx", tx, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", bus.d_in_ready, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_frame", frames_seen, base);
    check("t5_idle_busy", busy, 1'b0);
    check("t5_no_done", total_done, done0);
    push_ok(8'h3C);
    wait_frames(base + 1, 3 * FRAME);

    // Receiver loop-back patterns
    base = frames_seen;
    push_ok(8'h00);
    push_ok(8'h55);
    push_ok(8'hAA);
    push_ok(8'hFF);
    wait_frames(base + 4, 6 * FRAME);

    repeat (5) @(posedge clk);
    check("idle_err", idle_err, 0);
    check("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
